cim_mem_arbiter: RTL and testbench
==================================

# cim_mem_arbiter

Arbiter and sequencer for one CIM single-port memory (intermediate-results or parameters instance). It accepts independent request/grant handshakes from the four access sources (BUS_FSM, LOGIC_FSM, MAC, LAYERNORM) and drives exactly one one-hot `MemAccessSignals` request per cycle into the memory. It returns read data with a per-source valid strobe and enforces the MAC-is-read-only rule in hardware. Two instances sit between the CIM compute FSMs and `cim_mem`: one for int_res and one for params.

## Interface
- `ADDR_W`, default `$clog2(TEMP_RES_STORAGE_SIZE_CIM)`: address width; params instance overrides with `$clog2(PARAMS_STORAGE_SIZE_CIM)`.
- `N_SRC`, default 4: number of sources, indexed by the shared source enum (BUS_FSM=0, LOGIC_FSM=1, MAC=2, LAYERNORM=3).
- `clk`  in  1  clock; one clock domain, all logic on its rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `req`  in  N_SRC  per-source access request, level, held until granted.
- `we`  in  N_SRC  per-source write enable; 1 = write, 0 = read; valid with `req`.
- `lock`  in  N_SRC  per-source ownership hold; valid with `req`.
- `addr`  in  N_SRC x ADDR_W  per-source address.
- `wdata`  in  N_SRC x N_STORAGE  per-source write data.
- `gnt`  out  N_SRC  one-hot (or zero) grant; access is performed in the cycle `gnt` is high.
- `rvalid`  out  N_SRC  one-hot read-data-valid strobe.
- `rdata`  out  N_STORAGE  read data, passthrough of memory read data.
- `mem_access`  out  MemAccessSignals  request bundle to `cim_mem`.
- `mem_rdata`  in  N_STORAGE  read data from `cim_mem`.
- `err_mac_write`  out  1  sticky: MAC issued a write request.

## Operation
- Arbitration is evaluated combinationally every cycle over the eligible requests: `req[i]`, with MAC excluded whenever `we[MAC]=1`.
- Priority:
  - BUS_FSM always wins.
  - LOGIC_FSM, MAC and LAYERNORM are round-robin via pointer `rr_ptr`, which starts at LOGIC_FSM.
  - After a grant to source k among the three, `rr_ptr` moves to the next source after k in cyclic order.
  - A BUS_FSM grant leaves `rr_ptr` unchanged.
- Lock:
  - If the granted source has `lock=1`, register `owner <= source`.
  - While `owner` is valid, only `owner` is eligible, and BUS_FSM cannot preempt it.
  - `owner` clears on the first cycle where the owner presents `req=0` or `lock=0`. The grant in that cycle is re-arbitrated normally, so ownership release is same-cycle.
- `mem_access` mirrors `gnt`:
  - Write grant: `write_req_src = gnt`.
  - Read grant: `read_req_src = gnt`.
  - The granted source's `addr`/`wdata` are copied into its `addr_table`/`write_data` slot.
  - All other slots are zero.
- `err_mac_write` sets on any cycle with `req[MAC] & we[MAC]` and clears only on reset. The offending request is never granted.

## Timing
- Grant latency: `gnt` is asserted in the same cycle as `req` when the source wins, so zero-wait access is possible. A source holds `req`/`addr`/`wdata` stable until it sees `gnt`.
- Read latency:
  - A read granted in cycle N produces `rvalid[src]=1` and `rdata` valid in cycle N+1.
  - `rvalid` is a single-cycle pulse from a registered copy of `gnt & ~we`.
- Back-to-back: one grant per cycle; consecutive reads from different sources pipeline with no bubble.
- Writes produce no `rvalid`.
- Simultaneous requests from BUS_FSM and the locked owner: the owner wins and BUS_FSM waits.
- No requests: `gnt=0`, `mem_access` request fields all zero, and the memory performs a read at an undefined address, which is ignored.
- Reset values: `gnt=0`, `rvalid=0`, `mem_access` all zero, `owner` invalid, `rr_ptr=LOGIC_FSM`, `err_mac_write=0`. `rdata` follows `mem_rdata`.
- Reset asserted mid-operation: a pending `rvalid` is dropped and ownership is released.
- State registers: `owner` (valid + 2-bit id), `rr_ptr` (2 bits), `rvalid_q` (N_SRC bits), `err_mac_write`.

## Structure
- Shared package `cim_pkg`:
  - source enum: `BUS_FSM`, `LOGIC_FSM`, `MAC`, `LAYERNORM`, `N_SRC`
  - `MemAccessSignals` struct
  - `N_STORAGE`, `TEMP_RES_STORAGE_SIZE_CIM`, `PARAMS_STORAGE_SIZE_CIM`
- One sub-module, `rr_arbiter3`: 3-way round-robin with pointer input and one-hot grant output, purely combinational.
- Lock/owner logic, BUS_FSM priority and the read-valid pipeline stay in the top module.

## Test plan
- **Single read:** LOGIC_FSM reads addr 5 holding 0x1234 (preloaded) → `gnt[1]` in cycle 0, `rvalid[1]=1` and `rdata=0x1234` in cycle 1, nothing else asserted.
- **Priority/round-robin:** BUS_FSM, LOGIC_FSM, MAC and LAYERNORM request reads continuously from reset → grant order BUS_FSM ×4 while its req stays high. After BUS_FSM drops: LOGIC_FSM, MAC, LAYERNORM, LOGIC_FSM.
- **Lock:** LAYERNORM reads with `lock=1` for 3 cycles while BUS_FSM requests → LAYERNORM granted cycles 0–2, BUS_FSM granted cycle 3 when lock drops.
- **Pipeline:** MAC read addr 2, then LAYERNORM write addr 2 = 0xBEEF, then MAC read addr 2 → `rvalid[MAC]` cycles 1 and 3, second `rdata=0xBEEF`, no `rvalid` for the write.
- **MAC write:** MAC requests with `we=1` → never granted, `err_mac_write=1` from the next cycle, and it stays set after `req` drops.
- **Reset mid-read:** assert `rst` in the cycle after a read grant → `rvalid=0` immediately, `owner` cleared, `rr_ptr=LOGIC_FSM` on release.

Source files
------------

// File: rtl/cim_pkg.sv
// rtl/cim_pkg.sv - shared CIM memory types: source ids, storage sizes, memory request bundle
package cim_pkg;

  localparam int N_SRC                     = 4;
  localparam int N_STORAGE                 = 16;
  localparam int TEMP_RES_STORAGE_SIZE_CIM = 256;
  localparam int PARAMS_STORAGE_SIZE_CIM   = 512;
  // Request bundle carries the widest address so both instances share one type.
  localparam int MEM_ADDR_W = $clog2(PARAMS_STORAGE_SIZE_CIM);

  typedef enum logic [1:0] {
    BUS_FSM   = 2'd0,
    LOGIC_FSM = 2'd1,
    MAC       = 2'd2,
    LAYERNORM = 2'd3
  } src_e;

  typedef struct packed {
    logic [N_SRC-1:0]                 write_req_src;
    logic [N_SRC-1:0]                 read_req_src;
    logic [N_SRC-1:0][MEM_ADDR_W-1:0] addr_table;
    logic [N_SRC-1:0][N_STORAGE-1:0]  write_data;
  } MemAccessSignals;

endpackage

// File: rtl/cim_mem_arbiter_if.sv
// rtl/cim_mem_arbiter_if.sv - per-source request/grant/read-data bundle of the CIM memory arbiter
interface cim_mem_arbiter_if #(
  parameter int ADDR_W = $clog2(cim_pkg::TEMP_RES_STORAGE_SIZE_CIM)
) ();
  import cim_pkg::*;

  logic [N_SRC-1:0]                req;
  logic [N_SRC-1:0]                we;
  logic [N_SRC-1:0]                lock;
  logic [N_SRC-1:0][ADDR_W-1:0]    addr;
  logic [N_SRC-1:0][N_STORAGE-1:0] wdata;
  logic [N_SRC-1:0]                gnt;
  logic [N_SRC-1:0]                rvalid;
  logic [N_STORAGE-1:0]            rdata;

  modport master (output req, we, lock, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, lock, addr, wdata, output gnt, rvalid, rdata);

endinterface

// File: rtl/rr_arbiter3.sv
// rtl/rr_arbiter3.sv - combinational 3-way round-robin; i_ptr names the highest-priority slot
module rr_arbiter3 (
  input  logic [2:0] i_req,
  input  logic [1:0] i_ptr,
  output logic [2:0] o_gnt
);

  always_comb begin
    o_gnt = '0;
    for (int i = 0; i < 3; i++) begin
      logic [2:0] w_idx;
      w_idx = {1'b0, i_ptr} + 3'(i);
      if (w_idx >= 3'd3) w_idx = w_idx - 3'd3;
      if (o_gnt == '0 && i_req[w_idx[1:0]]) o_gnt[w_idx[1:0]] = 1'b1;
    end
  end

endmodule

// File: rtl/cim_mem_arbiter.sv
// rtl/cim_mem_arbiter.sv - single-port CIM memory arbiter: BUS_FSM priority, round-robin for the
// rest, lock ownership, one-cycle read-valid pipeline and MAC write trap
module cim_mem_arbiter
  import cim_pkg::*;
#(
  parameter int ADDR_W = $clog2(TEMP_RES_STORAGE_SIZE_CIM)
) (
  input  logic                 clk,
  input  logic                 rst,
  cim_mem_arbiter_if.slave     bus,
  output MemAccessSignals      mem_access,
  input  logic [N_STORAGE-1:0] mem_rdata,
  output logic                 err_mac_write
);

  logic [N_SRC-1:0] w_elig;
  logic [N_SRC-1:0] w_gnt;
  logic [2:0]       w_rr_gnt;
  logic [1:0]       w_rr_idx;
  logic             w_owner_hold;
  logic             w_owner_vld_nxt;
  src_e             w_owner_id_nxt;
  src_e             w_rr_ptr_nxt;

  logic             r_owner_vld;
  src_e             r_owner_id;
  src_e             r_rr_ptr;
  logic [N_SRC-1:0] r_rvalid_q;
  logic             r_err_mac_write;

  // MAC is read-only: a MAC write request is never eligible.
  always_comb begin
    w_elig = bus.req;
    if (bus.we[MAC]) w_elig[MAC] = 1'b0;
  end

  assign w_owner_hold = r_owner_vld & w_elig[r_owner_id] & bus.lock[r_owner_id];
  assign w_rr_idx     = r_rr_ptr - 2'd1;

  rr_arbiter3 u_rr (
    .i_req (w_elig[N_SRC-1:1]),
    .i_ptr (w_rr_idx),
    .o_gnt (w_rr_gnt)
  );

  always_comb begin
    w_gnt = '0;
    if (w_owner_hold)         w_gnt[r_owner_id] = 1'b1;
    else if (w_elig[BUS_FSM]) w_gnt[BUS_FSM]    = 1'b1;
    else                      w_gnt             = {w_rr_gnt, 1'b0};
  end

  always_comb begin
    w_rr_ptr_nxt = r_rr_ptr;
    if (w_gnt[LOGIC_FSM]) w_rr_ptr_nxt = MAC;
    if (w_gnt[MAC])       w_rr_ptr_nxt = LAYERNORM;
    if (w_gnt[LAYERNORM]) w_rr_ptr_nxt = LOGIC_FSM;
  end

  // Ownership is re-derived from the current grant, so release happens in the same cycle.
  always_comb begin
    w_owner_vld_nxt = 1'b0;
    w_owner_id_nxt  = r_owner_id;
    for (int i = 0; i < N_SRC; i++) begin
      if (w_gnt[i] && bus.lock[i]) begin
        w_owner_vld_nxt = 1'b1;
        w_owner_id_nxt  = src_e'(2'(i));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner_vld     <= 1'b0;
      r_owner_id      <= BUS_FSM;
      r_rr_ptr        <= LOGIC_FSM;
      r_rvalid_q      <= '0;
      r_err_mac_write <= 1'b0;
    end else begin
      r_owner_vld     <= w_owner_vld_nxt;
      r_owner_id      <= w_owner_id_nxt;
      r_rr_ptr        <= w_rr_ptr_nxt;
      r_rvalid_q      <= w_gnt & ~bus.we;
      r_err_mac_write <= r_err_mac_write | (bus.req[MAC] & bus.we[MAC]);
    end
  end

  always_comb begin
    mem_access = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (w_gnt[i]) begin
        mem_access.write_req_src[i] = bus.we[i];
        mem_access.read_req_src[i]  = ~bus.we[i];
        mem_access.addr_table[i]    = MEM_ADDR_W'(bus.addr[i]);
        mem_access.write_data[i]    = bus.wdata[i];
      end
    end
  end

  assign bus.gnt       = w_gnt;
  assign bus.rvalid    = r_rvalid_q;
  assign bus.rdata     = mem_rdata;
  assign err_mac_write = r_err_mac_write;

endmodule

// File: tb/tb_cim_mem_arbiter.sv
// tb/tb_cim_mem_arbiter.sv - directed self-checking bench for cim_mem_arbiter with a behavioural memory
module tb_cim_mem_arbiter;
  import cim_pkg::*;

  localparam int AW = $clog2(TEMP_RES_STORAGE_SIZE_CIM);

  logic                 clk;
  logic                 rst;
  MemAccessSignals      mem_access;
  logic [N_STORAGE-1:0] mem_rdata;
  logic                 err_mac_write;
  int                   n_vec;
  int                   n_err;

  logic [N_STORAGE-1:0] mem [0:PARAMS_STORAGE_SIZE_CIM-1];

  cim_mem_arbiter_if #(.ADDR_W(AW)) u_if ();

  cim_mem_arbiter #(.ADDR_W(AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (u_if.slave),
    .mem_access    (mem_access),
    .mem_rdata     (mem_rdata),
    .err_mac_write (err_mac_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port memory: write on the granted slot, registered read data one cycle later.
  always @(posedge clk) begin
    for (int i = 0; i < N_SRC; i++) begin
      if (mem_access.write_req_src[i]) mem[mem_access.addr_table[i]] = mem_access.write_data[i];
      if (mem_access.read_req_src[i])  mem_rdata <= mem[mem_access.addr_table[i]];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    u_if.req   = '0;
    u_if.we    = '0;
    u_if.lock  = '0;
    u_if.addr  = '0;
    u_if.wdata = '0;
  endtask

  task automatic apply_reset();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    step();
    #3;
    n_vec++; if (u_if.gnt !== 4'b0000) begin n_err++; $display("FAIL reset_gnt: got %b expected 0000", u_if.gnt); end
    n_vec++; if (u_if.rvalid !== 4'b0000) begin n_err++; $display("FAIL reset_rvalid: got %b expected 0000", u_if.rvalid); end
    n_vec++; if (mem_access !== '0) begin n_err++; $display("FAIL reset_mem_access: got %h expected 0", mem_access); end
    n_vec++; if (err_mac_write !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b expected 0", err_mac_write); end
    n_vec++; if (dut.r_owner_vld !== 1'b0) begin n_err++; $display("FAIL reset_owner: got %b expected 0", dut.r_owner_vld); end
    n_vec++; if (dut.r_rr_ptr !== LOGIC_FSM) begin n_err++; $display("FAIL reset_rr_ptr: got %0d expected 1", dut.r_rr_ptr); end
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    apply_reset();
    mem[5] = 16'h1234;
    step();
    u_if.req[LOGIC_FSM]  = 1'b1;
    u_if.addr[LOGIC_FSM] = AW'(5);
    #3;
    n_vec++; if (u_if.gnt !== 4'b0010) begin n_err++; $display("FAIL single_gnt: got %b expected 0010", u_if.gnt); end
    n_vec++; if (mem_access.read_req_src !== 4'b0010 || mem_access.write_req_src !== 4'b0000)
      begin n_err++; $display("FAIL single_req_src: got rd %b wr %b expected rd 0010 wr 0000", mem_access.read_req_src, mem_access.write_req_src); end
    n_vec++; if (mem_access.addr_table !== {9'd0, 9'd0, 9'd5, 9'd0}) begin n_err++; $display("FAIL single_addr_table: got %h expected slot1=5 only", mem_access.addr_table); end
    step();
    idle();
    #3;
    n_vec++; if (u_if.rvalid !== 4'b0010) begin n_err++; $display("FAIL single_rvalid: got %b expected 0010", u_if.rvalid); end
    n_vec++; if (u_if.rdata !== 16'h1234) begin n_err++; $display("FAIL single_rdata: got %h expected 1234", u_if.rdata); end
    n_vec++; if (u_if.gnt !== 4'b0000) begin n_err++; $display("FAIL single_gnt_after: got %b expected 0000", u_if.gnt); end
  endtask

  task automatic test_priority_rr();
    logic [3:0] exp_g [8];
    exp_g = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0010};
    apply_reset();
    for (int c = 0; c < 8; c++) begin
      step();
      u_if.req = (c < 4) ? 4'b1111 : 4'b1110;
      #3;
      n_vec++; if (u_if.gnt !== exp_g[c]) begin n_err++; $display("FAIL prio_rr_gnt cycle %0d: got %b expected %b", c, u_if.gnt, exp_g[c]); end
    end
    step();
    idle();
  endtask

  task automatic test_lock();
    logic [3:0] exp_g [4];
    exp_g = '{4'b1000, 4'b1000, 4'b1000, 4'b0001};
    apply_reset();
    for (int c = 0; c < 4; c++) begin
      step();
      u_if.req[LAYERNORM]  = (c < 3);
      u_if.lock[LAYERNORM] = (c < 3);
      u_if.addr[LAYERNORM] = AW'(7);
      u_if.req[BUS_FSM]    = (c > 0);
      #3;
      n_vec++; if (u_if.gnt !== exp_g[c]) begin n_err++; $display("FAIL lock_gnt cycle %0d: got %b expected %b", c, u_if.gnt, exp_g[c]); end
    end
    step();
    idle();
    #3;
    n_vec++; if (dut.r_owner_vld !== 1'b0) begin n_err++; $display("FAIL lock_release: owner valid got %b expected 0", dut.r_owner_vld); end
  endtask

  task automatic test_pipeline();
    apply_reset();
    mem[2] = 16'h0011;
    step();
    u_if.req[MAC]  = 1'b1;
    u_if.addr[MAC] = AW'(2);
    #3;
    n_vec++; if (u_if.gnt !== 4'b0100) begin n_err++; $display("FAIL pipe_gnt0: got %b expected 0100", u_if.gnt); end
    step();
    u_if.req[MAC]         = 1'b0;
    u_if.req[LAYERNORM]   = 1'b1;
    u_if.we[LAYERNORM]    = 1'b1;
    u_if.addr[LAYERNORM]  = AW'(2);
    u_if.wdata[LAYERNORM] = 16'hBEEF;
    #3;
    n_vec++; if (u_if.gnt !== 4'b1000) begin n_err++; $display("FAIL pipe_gnt1: got %b expected 1000", u_if.gnt); end
    n_vec++; if (mem_access.write_req_src !== 4'b1000 || mem_access.write_data[3] !== 16'hBEEF)
      begin n_err++; $display("FAIL pipe_write_bundle: got wr %b data %h expected 1000 beef", mem_access.write_req_src, mem_access.write_data[3]); end
    n_vec++; if (u_if.rvalid !== 4'b0100 || u_if.rdata !== 16'h0011)
      begin n_err++; $display("FAIL pipe_rvalid1: got %b/%h expected 0100/0011", u_if.rvalid, u_if.rdata); end
    step();
    idle();
    u_if.req[MAC]  = 1'b1;
    u_if.addr[MAC] = AW'(2);
    #3;
    n_vec++; if (u_if.gnt !== 4'b0100) begin n_err++; $display("FAIL pipe_gnt2: got %b expected 0100", u_if.gnt); end
    n_vec++; if (u_if.rvalid !== 4'b0000) begin n_err++; $display("FAIL pipe_write_rvalid: got %b expected 0000", u_if.rvalid); end
    step();
    idle();
    #3;
    n_vec++; if (u_if.rvalid !== 4'b0100 || u_if.rdata !== 16'hBEEF)
      begin n_err++; $display("FAIL pipe_rvalid3: got %b/%h expected 0100/beef", u_if.rvalid, u_if.rdata); end
  endtask

  task automatic test_mac_write();
    apply_reset();
    step();
    u_if.req[MAC]   = 1'b1;
    u_if.we[MAC]    = 1'b1;
    u_if.addr[MAC]  = AW'(9);
    u_if.wdata[MAC] = 16'hDEAD;
    #3;
    n_vec++; if (u_if.gnt !== 4'b0000 || mem_access !== '0) begin n_err++; $display("FAIL macw_gnt0: got gnt %b expected 0000 and idle bundle", u_if.gnt); end
    n_vec++; if (err_mac_write !== 1'b0) begin n_err++; $display("FAIL macw_err0: got %b expected 0", err_mac_write); end
    step();
    #3;
    n_vec++; if (u_if.gnt !== 4'b0000) begin n_err++; $display("FAIL macw_gnt1: got %b expected 0000", u_if.gnt); end
    n_vec++; if (err_mac_write !== 1'b1) begin n_err++; $display("FAIL macw_err1: got %b expected 1", err_mac_write); end
    step();
    idle();
    step();
    #3;
    n_vec++; if (err_mac_write !== 1'b1) begin n_err++; $display("FAIL macw_sticky: got %b expected 1", err_mac_write); end
  endtask

  task automatic test_reset_mid_read();
    apply_reset();
    step();
    u_if.req[LOGIC_FSM]  = 1'b1;
    u_if.lock[LOGIC_FSM] = 1'b1;
    u_if.addr[LOGIC_FSM] = AW'(5);
    #3;
    n_vec++; if (u_if.gnt !== 4'b0010) begin n_err++; $display("FAIL rstmid_gnt: got %b expected 0010", u_if.gnt); end
    step();
    idle();
    n_vec++; if (u_if.rvalid !== 4'b0010) begin n_err++; $display("FAIL rstmid_pending: got %b expected 0010", u_if.rvalid); end
    rst = 1'b1;
    #1;
    n_vec++; if (u_if.rvalid !== 4'b0000) begin n_err++; $display("FAIL rstmid_rvalid: got %b expected 0000", u_if.rvalid); end
    n_vec++; if (dut.r_owner_vld !== 1'b0) begin n_err++; $display("FAIL rstmid_owner: got %b expected 0", dut.r_owner_vld); end
    n_vec++; if (dut.r_rr_ptr !== LOGIC_FSM) begin n_err++; $display("FAIL rstmid_rr_ptr: got %0d expected 1", dut.r_rr_ptr); end
    step();
    rst = 1'b0;
    u_if.req = 4'b1110;
    #3;
    n_vec++; if (u_if.gnt !== 4'b0010) begin n_err++; $display("FAIL rstmid_rr_after: got %b expected 0010", u_if.gnt); end
    step();
    idle();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    idle();
    test_reset();
    test_single_read();
    test_priority_rr();
    test_lock();
    test_pipeline();
    test_mac_write();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
